apb_spi_fifo_master: RTL and testbench

- Parametrised APB3 slave in the FPGA fabric of the cc3000fpga design, addressed through the MSS APB master window (MSSPSEL/MSSPADDR…).
- Provides an SPI master with TX/RX FIFOs and chip-select control for the CC3000 module.
- Generalises the single-UART, no-FIFO MSS path: data width, FIFO depth, chip-select count and SPI mode are configurable.
- Drives a level interrupt into FABINT.

---
 rtl/apb_spi_fifo_master.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_apb_spi_fifo_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_fifo_master.sv
// ---------------------------------------------------------------------------
// apb_spi_fifo_master
//
// APB3 slave that runs an SPI master with first-word-fall-through TX/RX
// FIFOs and software-controlled chip selects for the CC3000 module. It
// raises a level interrupt into FABINT.
//
// Registers (PADDR[4:2]):
//   0x00 DATA    write pushes TX, read pops RX (zero-extended)
//   0x04 STATUS  [0] tx_empty [1] tx_full [2] rx_empty [3] rx_full
//                [4] busy [5] rx_ovf [15:8] tx_count [23:16] rx_count
//   0x08 CTRL    [0] enable [1] cpol [2] cpha [3] clear rx_ovf (pulse)
//                [4] flush both FIFOs (pulse)
//   0x0C CLKDIV  SCLK half period is CLKDIV+1 SYSCLK cycles
//   0x10 CS      1 drives the matching CS_N low
//   0x14 INT_EN  [0] rx_not_empty [1] tx_empty [2] rx_ovf
//
// Ports:
//   SYSCLK, NSYSRESET        clock, asynchronous active-low reset
//   PSEL..PWDATA             APB3 request
//   PRDATA, PREADY, PSLVERR  APB3 response (zero wait states)
//   IRQ                      registered level interrupt
//   SCLK, MOSI, MISO, CS_N   SPI bus
// ---------------------------------------------------------------------------
module apb_spi_fifo_master #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CS     = 1,
    parameter int CLKDIV_W   = 8
) (
    input  logic              SYSCLK,
    input  logic              NSYSRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [4:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              IRQ,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NUM_CS-1:0] CS_N
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Software-visible registers
    logic                r_en;
    logic                r_cpol;
    logic                r_cpha;
    logic [CLKDIV_W-1:0] r_clkdiv;
    logic [NUM_CS-1:0]   r_cs;
    logic [2:0]          r_int_en;
    logic                r_rx_ovf;
    logic                r_irq;

    // Per-word engine state
    logic                r_word_cpha;
    logic [CLKDIV_W-1:0] r_word_div;
    logic [CLKDIV_W-1:0] r_div_cnt;
    logic [EW-1:0]       r_edge_cnt;
    logic                r_sclk;
    logic                r_mosi;
    logic [DATA_W-1:0]   r_tx_sh;
    logic [DATA_W-1:0]   r_rx_sh;

    // FIFOs
    logic [DATA_W-1:0]   r_tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_rx_mem [FIFO_DEPTH];
    logic [CW-1:0]       r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;

    logic [CW-1:0]       w_tx_cnt, w_rx_cnt;
    logic                w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic [DATA_W-1:0]   w_tx_head, w_rx_head;

    logic                w_acc, w_wr, w_rd;
    logic [2:0]          w_idx;
    logic                w_tx_push, w_rx_pop, w_ctrl_wr, w_flush;
    logic                w_tx_pop, w_rx_push_req, w_rx_push, w_rx_we;
    logic [AW-1:0]       w_rx_waddr;
    logic                w_ovf_set;
    logic                w_tick, w_edge, w_lead, w_sample, w_shift_out;
    logic [31:0]         w_status;
    logic                w_unused;

    // -----------------------------------------------------------------------
    // FIFO flags; pointers carry one extra wrap bit
    // -----------------------------------------------------------------------
    assign w_tx_cnt   = r_tx_wp - r_tx_rp;
    assign w_rx_cnt   = r_rx_wp - r_rx_rp;
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_tx_full  = (w_tx_cnt == DEPTH_C);
    assign w_rx_full  = (w_rx_cnt == DEPTH_C);
    assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
    assign w_rx_head  = r_rx_mem[r_rx_rp[AW-1:0]];

    // -----------------------------------------------------------------------
    // APB decode
    // -----------------------------------------------------------------------
    assign w_acc     = PSEL & PENABLE;
    assign w_wr      = w_acc & PWRITE;
    assign w_rd      = w_acc & ~PWRITE;
    assign w_idx     = PADDR[4:2];
    assign w_tx_push = w_wr & (w_idx == 3'd0) & ~w_tx_full;
    assign w_rx_pop  = w_rd & (w_idx == 3'd0) & ~w_rx_empty;
    assign w_ctrl_wr = w_wr & (w_idx == 3'd2);
    assign w_flush   = w_ctrl_wr & PWDATA[4];

    // A finished word may still land when RX is full if software pops in
    // the same cycle. A word finishing on the flush cycle survives the flush.
    assign w_rx_push  = w_rx_push_req & (~w_rx_full | w_rx_pop);
    assign w_rx_we    = w_flush ? w_rx_push_req : w_rx_push;
    assign w_rx_waddr = w_flush ? '0 : r_rx_wp[AW-1:0];
    assign w_ovf_set  = ~w_flush & w_rx_push_req & w_rx_full & ~w_rx_pop;

    // -----------------------------------------------------------------------
    // SCLK edge timing. Even edge indices are leading edges; cpha selects
    // whether the leading edge samples (0) or shifts out (1).
    // -----------------------------------------------------------------------
    assign w_tick      = (r_div_cnt == r_word_div);
    assign w_edge      = (r_state == S_SHIFT) & w_tick;
    assign w_lead      = ~r_edge_cnt[0];
    assign w_sample    = w_edge & (w_lead ^ r_word_cpha);
    assign w_shift_out = w_edge & ~(w_lead ^ r_word_cpha);

    assign w_unused = ^{PWDATA, PADDR[1:0]};

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_tx_pop      = 1'b0;
        w_rx_push_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en && !w_tx_empty) begin
                    w_tx_pop = 1'b1;
                    w_next   = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_tick) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_tick && (r_edge_cnt == LAST_EDGE)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_rx_push_req = 1'b1;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Word engine: divider, edge counter, SCLK and MOSI
    // -----------------------------------------------------------------------
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_div_cnt   <= '0;
            r_edge_cnt  <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_word_cpha <= 1'b0;
            r_word_div  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_div_cnt  <= '0;
                    r_edge_cnt <= '0;
                    r_sclk     <= r_cpol;
                    // Mode and divider are frozen for the whole word
                    if (w_tx_pop) begin
                        r_word_cpha <= r_cpha;
                        r_word_div  <= r_clkdiv;
                        if (!r_cpha) begin
                            r_mosi <= w_tx_head[DATA_W-1];
                        end
                    end
                end
                S_LEAD: begin
                    r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_div_cnt  <= '0;
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // With cpha=0 the MSB is already on MOSI, so trailing edges
            // present the next bit; with cpha=1 leading edges present it.
            if (w_shift_out) begin
                r_mosi <= r_word_cpha ? r_tx_sh[DATA_W-1] : r_tx_sh[DATA_W-2];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data storage and shift registers (no reset needed)
    // -----------------------------------------------------------------------
    always_ff @(posedge SYSCLK) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp[AW-1:0]] <= PWDATA[DATA_W-1:0];
        end
        if (w_rx_we) begin
            r_rx_mem[w_rx_waddr] <= r_rx_sh;
        end
        if (w_tx_pop) begin
            r_tx_sh <= w_tx_head;
        end else if (w_shift_out) begin
            r_tx_sh <= r_tx_sh << 1;
        end
        if (w_sample) begin
            r_rx_sh <= {r_rx_sh[DATA_W-2:0], MISO};
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else if (w_flush) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_rp <= '0;
            r_rx_wp <= w_rx_push_req ? CW'(1) : '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Control registers and interrupt
    // -----------------------------------------------------------------------
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_en     <= 1'b0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_clkdiv <= '0;
            r_cs     <= '0;
            r_int_en <= '0;
            r_rx_ovf <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr) begin
                case (w_idx)
                    3'd2: begin
                        r_en   <= PWDATA[0];
                        r_cpol <= PWDATA[1];
                        r_cpha <= PWDATA[2];
                    end
                    3'd3: r_clkdiv <= PWDATA[CLKDIV_W-1:0];
                    3'd4: r_cs     <= PWDATA[NUM_CS-1:0];
                    3'd5: r_int_en <= PWDATA[2:0];
                    default: ;
                endcase
            end
            // A fresh overflow wins over a simultaneous clear
            if (w_ovf_set) begin
                r_rx_ovf <= 1'b1;
            end else if (w_ctrl_wr && PWDATA[3]) begin
                r_rx_ovf <= 1'b0;
            end
            r_irq <= (~w_rx_empty & r_int_en[0]) |
                     (w_tx_empty & r_int_en[1]) |
                     (r_rx_ovf & r_int_en[2]);
        end
    end

    // -----------------------------------------------------------------------
    // APB read path
    // -----------------------------------------------------------------------
    always_comb begin
        w_status        = '0;
        w_status[0]     = w_tx_empty;
        w_status[1]     = w_tx_full;
        w_status[2]     = w_rx_empty;
        w_status[3]     = w_rx_full;
        w_status[4]     = (r_state != S_IDLE);
        w_status[5]     = r_rx_ovf;
        w_status[15:8]  = 8'(w_tx_cnt);
        w_status[23:16] = 8'(w_rx_cnt);
    end

    always_comb begin
        PRDATA  = '0;
        PSLVERR = 1'b0;
        if (w_acc) begin
            case (w_idx)
                3'd0: begin
                    if (PWRITE) begin
                        PSLVERR = w_tx_full;
                    end else if (w_rx_empty) begin
                        PSLVERR = 1'b1;
                    end else begin
                        PRDATA[DATA_W-1:0] = w_rx_head;
                    end
                end
                3'd1: if (!PWRITE) PRDATA = w_status;
                3'd2: if (!PWRITE) PRDATA[2:0] = {r_cpha, r_cpol, r_en};
                3'd3: if (!PWRITE) PRDATA[CLKDIV_W-1:0] = r_clkdiv;
                3'd4: if (!PWRITE) PRDATA[NUM_CS-1:0] = r_cs;
                3'd5: if (!PWRITE) PRDATA[2:0] = r_int_en;
                default: PSLVERR = 1'b1;
            endcase
        end
    end

    assign PREADY = 1'b1;
    assign IRQ    = r_irq;
    assign SCLK   = r_sclk;
    assign MOSI   = r_mosi;
    assign CS_N   = ~r_cs;

endmodule

// File: tb/tb_apb_spi_fifo_master.sv
module tb_apb_spi_fifo_master;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int NUM_CS     = 1;
    localparam int CLKDIV_W   = 8;

    logic              SYSCLK = 1'b0;
    logic              NSYSRESET;
    logic              PSEL, PENABLE, PWRITE;
    logic [4:0]        PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR, IRQ, SCLK, MOSI, MISO;
    logic [NUM_CS-1:0] CS_N;

    logic       loop;
    logic       slave_miso = 1'b1;
    logic [7:0] slave_word = 8'hFF;
    int         neg_cnt = 0;
    int         neg_base = 0;
    int         pulses = 0;
    logic [7:0] mon_word = 8'h00;
    time        t_edge [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    always #5 SYSCLK = ~SYSCLK;

    assign MISO = loop ? MOSI : slave_miso;

    apb_spi_fifo_master #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .NUM_CS(NUM_CS), .CLKDIV_W(CLKDIV_W)
    ) dut (
        .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .IRQ(IRQ), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_N(CS_N)
    );

    // Bus monitor / slave receiver: MOSI captured on every SCLK rise
    always @(posedge SCLK) begin
        if (pulses < 1024) t_edge[pulses] = $time;
        pulses   = pulses + 1;
        mon_word = {mon_word[6:0], MOSI};
    end

    // Slave transmitter for cpha=1: next bit presented on each falling edge
    always @(negedge SCLK) begin
        if ((neg_cnt - neg_base) < 8 && (neg_cnt - neg_base) >= 0)
            slave_miso = slave_word[7 - (neg_cnt - neg_base)];
        neg_cnt = neg_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
        @(posedge SYSCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge SYSCLK); #1;
        PENABLE = 1'b1;
        #2 err = PSLVERR;
        @(posedge SYSCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic err);
        @(posedge SYSCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge SYSCLK); #1;
        PENABLE = 1'b1;
        #2 begin d = PRDATA; err = PSLVERR; end
        @(posedge SYSCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        logic        e;
        int          n;
        repeat (4) @(posedge SYSCLK);
        n  = 0;
        st = 32'h10;
        while (n < 3000) begin
            apb_read(5'h04, st, e);
            if (!st[4] && st[0]) break;
            n++;
        end
        check(tag, {31'b0, st[4]}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          base;

        NSYSRESET = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        loop = 1'b0;

        // Reset state
        repeat (3) @(posedge SYSCLK);
        #1;
        check("rst_cs_n",   32'(CS_N), 32'h1);
        check("rst_sclk",   32'(SCLK), 32'h0);
        check("rst_irq",    32'(IRQ), 32'h0);
        check("rst_mosi",   32'(MOSI), 32'h0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        @(posedge SYSCLK); #1 NSYSRESET = 1'b1;
        apb_read(5'h04, rd, err);
        check("rst_status", rd, 32'h0000_0005);

        // Loopback, mode 0, CLKDIV=1
        loop = 1'b1;
        wr(5'h0C, 32'd1);
        wr(5'h10, 32'd1);
        check("cs_asserted", 32'(CS_N), 32'h0);
        wr(5'h08, 32'h1);
        base = pulses;
        wr(5'h00, 32'hA5);
        wait_idle("m0_idle");
        check("m0_pulses", 32'(pulses - base), 32'd8);
        check("m0_mosi_bits", {24'b0, mon_word}, 32'hA5);
        check("m0_sclk_period", 32'(t_edge[base+1] - t_edge[base]), 32'd40);
        apb_read(5'h00, rd, err);
        check("m0_rx", rd, 32'hA5);
        check("m0_rx_err", 32'(err), 32'h0);
        apb_read(5'h04, rd, err);
        check("m0_status", rd, 32'h0000_0005);

        // Mode 3 against slave model
        wr(5'h08, 32'h7);
        repeat (2) @(posedge SYSCLK);
        #1 check("m3_sclk_idle", 32'(SCLK), 32'h1);
        loop       = 1'b0;
        slave_word = 8'h3C;
        neg_base   = neg_cnt;
        base       = pulses;
        wr(5'h00, 32'hC3);
        wait_idle("m3_idle");
        check("m3_pulses", 32'(pulses - base), 32'd8);
        check("m3_slave_rx", {24'b0, mon_word}, 32'hC3);
        check("m3_sclk_end", 32'(SCLK), 32'h1);
        apb_read(5'h00, rd, err);
        check("m3_rx", rd, 32'h3C);

        // Fill TX while disabled
        wr(5'h08, 32'h0);
        repeat (2) @(posedge SYSCLK);
        loop = 1'b1;
        for (int i = 0; i < 16; i++) wr(5'h00, 32'h10 + 32'(i));
        apb_read(5'h04, rd, err);
        check("fill_status", rd, 32'h0000_1006);
        apb_write(5'h00, 32'h99, err);
        check("fill_17th_err", 32'(err), 32'h1);
        apb_read(5'h04, rd, err);
        check("fill_status_after", rd, 32'h0000_1006);
        base = pulses;
        wr(5'h08, 32'h1);
        wait_idle("b2b_idle");
        check("b2b_pulses", 32'(pulses - base), 32'd128);
        check("b2b_span", 32'(t_edge[base+127] - t_edge[base]), 32'd5680);
        apb_read(5'h04, rd, err);
        check("b2b_status", rd, 32'h0010_0009);
        check("b2b_irq", 32'(IRQ), 32'h0);

        // RX overflow with a 17th word
        wr(5'h00, 32'h55);
        wait_idle("ovf_idle");
        apb_read(5'h04, rd, err);
        check("ovf_status", rd, 32'h0010_0029);
        wr(5'h14, 32'h4);
        @(posedge SYSCLK); #1;
        check("ovf_irq", 32'(IRQ), 32'h1);
        wr(5'h08, 32'h9);
        apb_read(5'h04, rd, err);
        check("ovf_cleared", rd, 32'h0010_0009);
        check("ovf_irq_clear", 32'(IRQ), 32'h0);
        for (int i = 0; i < 16; i++) begin
            apb_read(5'h00, rd, err);
            check($sformatf("rx_order_%0d", i), rd, 32'h10 + 32'(i));
        end
        apb_read(5'h04, rd, err);
        check("drain_status", rd, 32'h0000_0005);

        // Error cases
        apb_read(5'h00, rd, err);
        check("empty_rd_err", 32'(err), 32'h1);
        check("empty_rd_data", rd, 32'h0);
        apb_write(5'h18, 32'hFFFF_FFFF, err);
        check("bad_wr_err", 32'(err), 32'h1);
        apb_read(5'h1C, rd, err);
        check("bad_rd_err", 32'(err), 32'h1);
        check("bad_rd_data", rd, 32'h0);

        // Reset pulse mid-word
        wr(5'h0C, 32'd3);
        wr(5'h00, 32'h81);
        wr(5'h00, 32'h7E);
        repeat (20) @(posedge SYSCLK);
        #3 NSYSRESET = 1'b0;
        #1;
        check("mid_rst_cs_n", 32'(CS_N), 32'h1);
        check("mid_rst_sclk", 32'(SCLK), 32'h0);
        check("mid_rst_mosi", 32'(MOSI), 32'h0);
        repeat (2) @(posedge SYSCLK);
        #1 NSYSRESET = 1'b1;
        apb_read(5'h04, rd, err);
        check("mid_rst_status", rd, 32'h0000_0005);
        apb_read(5'h08, rd, err);
        check("mid_rst_ctrl", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
